// File: rtl/shifter_video_planar_if.sv
// Video shifter bus bundle: pixel tick, word-load strobe and video word
// from the MCU side, mode controls, and the Reload / underrun / colour
// index outputs towards the palette.
//   master : drives pixClkEn, DE, LOAD, rez, monocolor, DIN, hscroll
//   slave  : drives Reload, underrun, color_index
interface shifter_video_planar_if #(
  parameter int unsigned PLANES   = 4,
  parameter int unsigned WORD_W   = 16,
  parameter int unsigned SCROLL_W = 4
);
  logic                pixClkEn;
  logic                DE;
  logic                LOAD;
  logic [1:0]          rez;
  logic                monocolor;
  logic [WORD_W-1:0]   DIN;
  logic [SCROLL_W-1:0] hscroll;
  logic                Reload;
  logic                underrun;
  logic [PLANES-1:0]   color_index;

  modport master (
    output pixClkEn, DE, LOAD, rez, monocolor, DIN, hscroll,
    input  Reload, underrun, color_index
  );

  modport slave (
    input  pixClkEn, DE, LOAD, rez, monocolor, DIN, hscroll,
    output Reload, underrun, color_index
  );
endinterface

// File: rtl/shifter_video_planar.sv
// Parametrised planar video shifter. Words arriving on LOAD edges fill a
// bank of PLANES latches; at each group boundary the latches move into the
// shift registers, which are cascaded according to the line's resolution
// (low / mid / mono) to produce one colour index per pixel tick. A fine
// horizontal scroll pre-shifts the first group of each line, and a group
// reload with an incomplete latch set raises a one-cycle underrun pulse.
//   clk32  : system clock, all logic on posedge
//   nReset : asynchronous active-low reset
//   bus    : shifter_video_planar_if slave port (inputs from MCU, outputs
//            Reload / underrun / color_index, all registered)
module shifter_video_planar #(
  parameter int unsigned PLANES   = 4,
  parameter int unsigned WORD_W   = 16,
  parameter int unsigned SCROLL_W = 4
) (
  input  logic                   clk32,
  input  logic                   nReset,
  shifter_video_planar_if.slave  bus
);

  localparam int unsigned PC_W  = (WORD_W * PLANES > 1) ? $clog2(WORD_W * PLANES) : 1;
  localparam int unsigned CNT_W = $clog2(PLANES + 1);
  localparam int unsigned A_MID = (PLANES > 1) ? PLANES / 2 : 1;
  localparam int unsigned SH_W  = SCROLL_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_START,
    S_RUN,
    S_DRAIN
  } state_e;

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   lat_q [PLANES];
  logic [WORD_W-1:0]   lat_d [PLANES];
  logic [WORD_W-1:0]   sr_q  [PLANES];
  logic [WORD_W-1:0]   sr_d  [PLANES];
  logic [WORD_W-1:0]   pre_sr [PLANES];
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [PC_W-1:0]     pmax_q, pmax_d;
  logic [CNT_W-1:0]    load_cnt_q, load_cnt_d;
  logic [CNT_W-1:0]    a_q, a_d;
  logic                mono_q, mono_d;
  logic                load_dly_q, load_dly_d;
  logic                reload_q, reload_d;
  logic                underrun_q, underrun_d;
  logic [PLANES-1:0]   color_q, color_d;

  logic                load_edge;
  logic                capture;
  logic                reload_hit;
  logic [CNT_W-1:0]    cnt_next;
  logic [PLANES-1:0]   msb_vec;
  logic [PLANES-1:0]   cascade_in;
  logic [PLANES-1:0]   col;
  logic [SH_W-1:0]     rsh;

  // Cascade shift-in bits and the scroll-pre-shifted first group.
  always_comb begin : cascade
    logic [WORD_W-1:0] nb;
    for (int unsigned p = 0; p < PLANES; p++) msb_vec[p] = sr_q[p][WORD_W-1];
    // plane p is fed by plane p+A; planes with no upstream partner get 0
    cascade_in = msb_vec >> a_q;
    rsh = SH_W'(WORD_W) - SH_W'(bus.hscroll);
    for (int unsigned p = 0; p < PLANES; p++) begin
      nb = '0;
      for (int unsigned q = 0; q < PLANES; q++) begin
        if (q == p + 32'(a_q)) nb = lat_q[q];
      end
      // a shift by the full word width (hscroll=0) yields 0
      pre_sr[p] = (lat_q[p] << bus.hscroll) | (nb >> rsh);
    end
  end

  // Next-state, datapath and output computation.
  always_comb begin : next_state
    state_d    = state_q;
    lat_d      = lat_q;
    sr_d       = sr_q;
    pc_d       = pc_q;
    pmax_d     = pmax_q;
    load_cnt_d = load_cnt_q;
    a_d        = a_q;
    mono_d     = mono_q;
    reload_d   = reload_q;
    underrun_d = 1'b0;
    load_dly_d = bus.LOAD;

    load_edge  = bus.LOAD & ~load_dly_q;
    capture    = load_edge & ((state_q != S_IDLE) | bus.DE);
    reload_hit = (pmax_q == '0) | (pc_q == pmax_q - PC_W'(1));
    cnt_next   = (load_cnt_q >= CNT_W'(PLANES)) ? load_cnt_q : load_cnt_q + CNT_W'(1);

    if (capture) begin
      lat_d[PLANES-1] = bus.DIN;
      for (int unsigned k = 0; k + 1 < PLANES; k++) lat_d[k] = lat_q[k+1];
      load_cnt_d = cnt_next;
    end

    if (bus.pixClkEn) begin
      reload_d = (state_q == S_RUN) & reload_hit;
      if (reload_q) begin
        // group boundary: sr takes pre-edge latches, a same-cycle load counts as 1
        sr_d       = lat_q;
        pc_d       = '0;
        load_cnt_d = CNT_W'(capture);
        underrun_d = (load_cnt_q < CNT_W'(PLANES));
      end else begin
        for (int unsigned p = 0; p < PLANES; p++) sr_d[p] = {sr_q[p][WORD_W-2:0], cascade_in[p]};
        if (state_q == S_RUN || state_q == S_DRAIN) pc_d = pc_q + PC_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        pc_d = '0;
        if (capture) begin
          state_d = S_FILL;
          // mode is frozen for the whole line from here on
          case (bus.rez)
            2'd0: begin
              a_d    = CNT_W'(PLANES);
              mono_d = 1'b0;
              pmax_d = PC_W'(WORD_W - 1);
            end
            2'd1: begin
              a_d    = CNT_W'(A_MID);
              mono_d = 1'b0;
              pmax_d = PC_W'(WORD_W * PLANES / A_MID - 1);
            end
            default: begin
              a_d    = CNT_W'(1);
              mono_d = 1'b1;
              pmax_d = PC_W'(WORD_W * PLANES - 1);
            end
          endcase
        end
      end
      S_FILL: begin
        if (load_cnt_q == CNT_W'(PLANES)) state_d = S_START;
      end
      S_START: begin
        if (bus.pixClkEn) begin
          sr_d       = pre_sr;
          pc_d       = PC_W'(bus.hscroll);
          load_cnt_d = CNT_W'(capture);
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        if (!bus.DE) begin
          state_d  = S_DRAIN;
          reload_d = 1'b0;
        end
      end
      S_DRAIN: begin
        if (bus.pixClkEn && pc_q == pmax_q) begin
          state_d    = S_IDLE;
          pc_d       = '0;
          load_cnt_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    for (int unsigned i = 0; i < PLANES; i++) col[i] = sr_d[i][WORD_W-1];
    color_d = (col & ~({PLANES{1'b1}} << a_d)) ^ PLANES'(mono_d & bus.monocolor);
  end

  // State and datapath registers.
  always_ff @(posedge clk32 or negedge nReset) begin
    if (!nReset) begin
      state_q    <= S_IDLE;
      lat_q      <= '{default: '0};
      sr_q       <= '{default: '0};
      pc_q       <= '0;
      pmax_q     <= '0;
      load_cnt_q <= '0;
      a_q        <= '0;
      mono_q     <= 1'b0;
      load_dly_q <= 1'b0;
      reload_q   <= 1'b0;
      underrun_q <= 1'b0;
      color_q    <= '0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      sr_q       <= sr_d;
      pc_q       <= pc_d;
      pmax_q     <= pmax_d;
      load_cnt_q <= load_cnt_d;
      a_q        <= a_d;
      mono_q     <= mono_d;
      load_dly_q <= load_dly_d;
      reload_q   <= reload_d;
      underrun_q <= underrun_d;
      color_q    <= color_d;
    end
  end

  assign bus.Reload      = reload_q;
  assign bus.underrun    = underrun_q;
  assign bus.color_index = color_q;

endmodule

// File: tb/tb_shifter_video_planar.sv
// Testbench for shifter_video_planar: directed lines from the test plan plus
// randomized lines, checked against a pixel-stream model that reads each
// colour bit straight out of the chained plane words of the current group.
module tb_shifter_video_planar;

  localparam int unsigned PLANES   = 4;
  localparam int unsigned WORD_W   = 16;
  localparam int unsigned SCROLL_W = 4;
  localparam int unsigned MAXG     = 4;

  logic clk32 = 1'b0;
  logic nReset;

  always #5 clk32 = ~clk32;

  shifter_video_planar_if #(.PLANES(PLANES), .WORD_W(WORD_W), .SCROLL_W(SCROLL_W)) bus ();

  shifter_video_planar #(.PLANES(PLANES), .WORD_W(WORD_W), .SCROLL_W(SCROLL_W)) dut (
    .clk32  (clk32),
    .nReset (nReset),
    .bus    (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [WORD_W-1:0] hist [$];
  logic [WORD_W-1:0] feed [$];
  logic [WORD_W-1:0] grp  [PLANES];
  int                nload [MAXG];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Latches always hold the last PLANES words loaded, oldest in plane 0.
  task automatic set_grp();
    for (int k = 0; k < PLANES; k++) grp[k] = hist[hist.size() - PLANES + k];
  endtask

  // Pixel pos of a group: colour bit b follows the chain of planes b, b+A, ...
  function automatic logic [PLANES-1:0] exp_pix(input int a, input int plen, input int pos,
                                                input bit mono, input bit mc);
    logic [PLANES-1:0] r;
    int w;
    r = '0;
    for (int b = 0; b < a; b++) begin
      w = b + a * (pos / WORD_W);
      if (pos < plen && w < PLANES) r[b] = grp[w][WORD_W - 1 - (pos % WORD_W)];
    end
    if (mono) r[0] = r[0] ^ mc;
    return r;
  endfunction

  function automatic logic [WORD_W-1:0] next_word();
    logic [WORD_W-1:0] w;
    if (feed.size() > 0) w = feed.pop_front();
    else w = WORD_W'($urandom);
    return w;
  endfunction

  // One clk32 cycle: drive at negedge, return at the following negedge.
  task automatic step(input bit pix, input bit ld);
    bus.pixClkEn = pix;
    bus.LOAD     = ld;
    @(posedge clk32);
    @(negedge clk32);
  endtask

  task automatic load_word(input logic [WORD_W-1:0] w);
    bus.DIN = w;
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    hist.push_back(w);
  endtask

  task automatic run_line(input int rz, input int h, input bit mc, input int ng, input string tag);
    int a, plen, pos;
    bit mono;
    a    = (rz == 0) ? PLANES : (rz == 1) ? ((PLANES > 1) ? PLANES / 2 : 1) : 1;
    plen = WORD_W * PLANES / a;
    mono = (rz >= 2);
    bus.rez       = 2'(rz);
    bus.hscroll   = SCROLL_W'(h);
    bus.monocolor = mc;
    bus.DE        = 1'b1;
    hist.delete();
    for (int k = 0; k < PLANES; k++) load_word(next_word());
    step(1'b0, 1'b0);
    set_grp();
    pos = h;
    step(1'b1, 1'b0);
    check({tag, "_start_pix"}, 32'(bus.color_index), 32'(exp_pix(a, plen, pos, mono, mc)));
    check({tag, "_start_reload"}, 32'(bus.Reload), 32'(0));
    for (int g = 0; g < ng; g++) begin
      if (g < ng - 1) begin
        for (int k = 0; k < nload[g+1]; k++) load_word(next_word());
      end else begin
        bus.DE = 1'b0;
        step(1'b0, 1'b0);
      end
      while (pos < plen - 1) begin
        step(1'b1, 1'b0);
        pos++;
        check({tag, "_pix"}, 32'(bus.color_index), 32'(exp_pix(a, plen, pos, mono, mc)));
        check({tag, "_reload"}, 32'(bus.Reload), 32'((pos == plen - 1) && (g < ng - 1)));
        check({tag, "_underrun_idle"}, 32'(bus.underrun), 32'(0));
      end
      step(1'b1, 1'b0);
      if (g < ng - 1) begin
        set_grp();
        pos = 0;
        check({tag, "_grp_pix"}, 32'(bus.color_index), 32'(exp_pix(a, plen, pos, mono, mc)));
        check({tag, "_grp_underrun"}, 32'(bus.underrun), 32'(nload[g+1] < PLANES));
        check({tag, "_grp_reload"}, 32'(bus.Reload), 32'(0));
      end else begin
        pos = plen;
        check({tag, "_drain_pix"}, 32'(bus.color_index), 32'(exp_pix(a, plen, pos, mono, mc)));
        check({tag, "_drain_reload"}, 32'(bus.Reload), 32'(0));
        step(1'b1, 1'b0);
        check({tag, "_idle_pix"}, 32'(bus.color_index), 32'(exp_pix(a, plen, pos, mono, mc)));
        check({tag, "_idle_reload"}, 32'(bus.Reload), 32'(0));
      end
    end
  endtask

  initial begin
    nReset        = 1'b0;
    bus.pixClkEn  = 1'b0;
    bus.DE        = 1'b0;
    bus.LOAD      = 1'b0;
    bus.rez       = 2'd0;
    bus.monocolor = 1'b0;
    bus.DIN       = '0;
    bus.hscroll   = '0;
    for (int g = 0; g < MAXG; g++) nload[g] = PLANES;

    // reset state
    repeat (3) @(negedge clk32);
    check("reset_reload", 32'(bus.Reload), 32'(0));
    check("reset_underrun", 32'(bus.underrun), 32'(0));
    check("reset_color", 32'(bus.color_index), 32'(0));
    nReset = 1'b1;
    step(1'b0, 1'b0);

    // low res, single dot on planes 0 and 2
    feed = '{16'h8000, 16'h0000, 16'h8000, 16'h0000};
    run_line(0, 0, 1'b0, 2, "tp_low");

    // mid res: index 01 then 10
    feed = '{16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF};
    run_line(1, 0, 1'b0, 2, "tp_mid");

    // mono with inverted colour
    feed = '{16'hAAAA, 16'h0000, 16'h0000, 16'h0000};
    run_line(2, 0, 1'b1, 1, "tp_mono");

    // fine scroll of 5 pixels
    feed = '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
    run_line(0, 5, 1'b0, 3, "tp_scroll");

    // underrun: only two words loaded before the second group
    nload = '{PLANES, 2, PLANES, PLANES};
    run_line(0, 3, 1'b0, 3, "tp_underrun");
    for (int g = 0; g < MAXG; g++) nload[g] = PLANES;

    // asynchronous reset in the middle of a line
    bus.rez = 2'd0;
    bus.hscroll = '0;
    bus.DE = 1'b1;
    hist.delete();
    for (int k = 0; k < PLANES; k++) load_word(16'hFFFF);
    step(1'b0, 1'b0);
    set_grp();
    step(1'b1, 1'b0);
    for (int t = 0; t < WORD_W - 1; t++) step(1'b1, 1'b0);
    check("rst_pre_reload", 32'(bus.Reload), 32'(1));
    check("rst_pre_color", 32'(bus.color_index), 32'(exp_pix(PLANES, WORD_W, WORD_W - 1, 1'b0, 1'b0)));
    #2 nReset = 1'b0;
    #1;
    check("rst_async_reload", 32'(bus.Reload), 32'(0));
    check("rst_async_color", 32'(bus.color_index), 32'(0));
    check("rst_async_underrun", 32'(bus.underrun), 32'(0));
    @(negedge clk32);
    nReset = 1'b1;
    bus.DE = 1'b0;
    for (int k = 0; k < PLANES + 1; k++) load_word(16'hFFFF);
    step(1'b1, 1'b0);
    check("rst_idle_color", 32'(bus.color_index), 32'(0));
    check("rst_idle_reload", 32'(bus.Reload), 32'(0));
    run_line(0, 0, 1'b0, 2, "post_rst");

    // randomized lines
    for (int n = 0; n < 8; n++) begin
      int rz, h, ng;
      bit mc;
      rz = int'($urandom_range(3, 0));
      h  = (rz == 0) ? int'($urandom_range(WORD_W - 2, 0)) : int'($urandom_range(WORD_W - 1, 0));
      mc = 1'($urandom);
      ng = int'($urandom_range(3, 1));
      for (int g = 0; g < MAXG; g++)
        nload[g] = ($urandom_range(3, 0) == 0) ? int'($urandom_range(PLANES - 1, 1)) : PLANES;
      run_line(rz, h, mc, ng, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
